pin_frame_mux: RTL and testbench
================================

Name: pin_frame_mux

Overview:
- Parametrised pad-multiplexing bridge between a processor core (i8008-class or wider) and a narrow tapeout pin slot.
- Time-multiplexes the core's output word {sync, state, data} onto PIN_W output pins.
- Deserialises framed input words {ready, intr, data} from PIN_W input pins.
- Generates a core clock-enable so the core advances once per output frame.
- Generalises the fixed 12-pin direct wiring to arbitrary data widths.

Parameters:
- PIN_W, 12: pad pins per direction. Bit PIN_W-1 is the frame marker. Payload width P = PIN_W-1.
- DATA_W, 16: core data bus width.
- STATE_W, 3: core state field width.
- SYNC_STAGES, 2: flops in each input synchroniser, >= 2.

Ports:
- clock  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- io_in  in  PIN_W  pad inputs, asynchronous to clock.
- io_out  out  PIN_W  pad outputs.
- core_d_out  in  DATA_W  core data out.
- core_state  in  STATE_W  core state code.
- core_sync  in  1  core sync.
- core_d_in  out  DATA_W  deserialised data to core.
- core_intr  out  1  deserialised interrupt.
- core_ready  out  1  deserialised ready.
- core_ce  out  1  core clock enable, one-cycle pulse per output frame.
- frame_valid  out  1  one-cycle pulse on input frame commit.
- frame_err  out  1  one-cycle pulse on truncated input frame.

Behaviour:
- Reset is asynchronous and active-low: reset_n=0 immediately clears all flops, no clock required.
- Widths and beat counts:
  - OUT_W = DATA_W+STATE_W+1, out word = {core_sync, core_state, core_d_out}.
  - IN_W = DATA_W+2, in word = {ready, intr, d_in}.
  - OUT_B = ceil(OUT_W/P), IN_B = ceil(IN_W/P).
  - Chunk k is word bits [k*P +: P]. Out padding is 0; in padding bits are ignored.
- Reset values:
  - out_beat=0, snapshot=0, so io_out={1, zeros}.
  - core_d_in=0, core_intr=0, core_ready=0 (core stalls until the first valid frame).
  - frame_valid=0, frame_err=0, in_beat=0, synchronisers=0.
  - core_ce=1 iff OUT_B==1.
- Output side:
  - out_beat free-runs 0..OUT_B-1 and wraps.
  - io_out = {out_beat==0, snapshot chunk[out_beat]}, decoded only from registers.
  - core_ce = (out_beat==OUT_B-1), combinational from the counter.
  - snapshot loads {core_sync, core_state, core_d_out} on the edge ending a core_ce cycle. That is the same edge the core advances on, so it captures the core's pre-edge outputs.
  - The first post-reset frame transmits all-zero payload.
- Input side:
  - Every io_in bit passes through a SYNC_STAGES-deep synchroniser. m = synced marker, c = synced payload.
  - in_beat==0 (idle): m=1 stores c as chunk0 and sets in_beat=1; m=0 is ignored.
  - 0<in_beat<IN_B: m=0 stores chunk[in_beat] and increments in_beat. m=1 pulses frame_err, discards partial data, stores c as the new chunk0, sets in_beat=1.
  - Commit: on storing chunk IN_B-1, update core_d_in/core_intr/core_ready on that edge, pulse frame_valid, set in_beat=0.
  - IN_B==1: every m=1 cycle commits directly.
  - Outputs hold between commits.
- Latency: beat 0 on pins in cycle t → committed values visible in cycle t+IN_B+SYNC_STAGES. Defaults: 4 cycles.
- Back-to-back frames: a marker on the cycle after the last beat starts a new frame with no gap and no error.
- Reset mid-frame: partial input frame is lost, outputs return to reset values, output framing restarts at beat 0.

Test Plan:
- Reset hold: reset_n=0 asserted asynchronously mid-cycle → io_out=0x800 immediately; core_d_in=0, core_ready=0, frame_valid=0, frame_err=0.
- Output serialisation (defaults): core_d_out=0xA5C3, state=3'b101, sync=1 held → after one core_ce, frames repeat io_out=0xDC3 (beat 0) then 0x1B4 (beat 1); core_ce high on beat 1 only.
- Input frame:
  - Stimulus: io_in=0xA34, then 0x042, then 0x000.
  - Required response: 4 cycles after the 0xA34 cycle, core_d_in=0x1234, core_ready=1, core_intr=0, with a one-cycle frame_valid.
  - Values then hold.
- Truncated frame: 0xA34, then 0xA34 again, then 0x042 → one frame_err pulse aligned to the second marker; single commit of 0x1234; no commit from the first marker.
- Reset mid-input-frame: reset_n low for 1 cycle between beats 0 and 1 → no commit, outputs 0, a subsequent full frame commits normally.
- Parameter sweep: PIN_W=8, DATA_W=8, STATE_W=3 → OUT_B=2, IN_B=2. Repeat the serialise and deserialise checks with randomised words against a reference model.

Source files
------------

// File: rtl/pin_frame_mux.sv
// pin_frame_mux
//   Pad-multiplexing bridge between a processor core and a narrow pin slot.
//   The core output word {sync, state, data} is time-multiplexed onto PIN_W
//   output pins. Framed input words {ready, intr, data} are rebuilt from PIN_W
//   input pins. Pin PIN_W-1 carries the frame marker in both directions, and
//   the remaining PIN_W-1 pins carry one payload chunk per beat.
//
// Ports
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   io_in        pad inputs (asynchronous to clock)
//   io_out       pad outputs {marker, payload chunk}
//   core_d_out   core data out
//   core_state   core state code
//   core_sync    core sync
//   core_d_in    deserialised data to core (held between commits)
//   core_intr    deserialised interrupt (held between commits)
//   core_ready   deserialised ready (held between commits)
//   core_ce      core clock enable, high on the last beat of each output frame
//   frame_valid  one-cycle pulse when an input frame commits
//   frame_err    one-cycle pulse when an input frame is cut short by a marker
module pin_frame_mux #(
   parameter int PIN_W       = 12,
   parameter int DATA_W      = 16,
   parameter int STATE_W     = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [PIN_W-1:0]   io_in,
   output logic [PIN_W-1:0]   io_out,
   input  logic [DATA_W-1:0]  core_d_out,
   input  logic [STATE_W-1:0] core_state,
   input  logic               core_sync,
   output logic [DATA_W-1:0]  core_d_in,
   output logic               core_intr,
   output logic               core_ready,
   output logic               core_ce,
   output logic               frame_valid,
   output logic               frame_err
);

   localparam int P     = PIN_W - 1;
   localparam int OUT_W = DATA_W + STATE_W + 1;
   localparam int IN_W  = DATA_W + 2;
   localparam int OUT_B = (OUT_W + P - 1) / P;
   localparam int IN_B  = (IN_W + P - 1) / P;
   localparam int OSW   = OUT_B * P;
   localparam int ISW   = IN_B * P;
   localparam int OBW   = (OUT_B > 1) ? $clog2(OUT_B) : 1;
   localparam int IBW   = (IN_B > 1) ? $clog2(IN_B) : 1;

   localparam logic [OBW-1:0] OUT_LAST = OBW'(OUT_B - 1);
   localparam logic [IBW-1:0] IN_LAST  = IBW'(IN_B - 1);

   // ------------------------------------------------------------------
   // Output side
   // ------------------------------------------------------------------
   logic [OBW-1:0]   r_out_beat;
   logic [OSW-1:0]   r_snap;
   logic [OUT_W-1:0] w_out_word;
   logic [P-1:0]     w_out_chunk;

   assign w_out_word = {core_sync, core_state, core_d_out};

   // The core advances on the edge that ends this cycle.
   assign core_ce = (r_out_beat == OUT_LAST);

   // Snapshot is taken on the same edge the core advances, so it holds the
   // core's pre-edge outputs for the whole of the next frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_beat <= '0;
         r_snap     <= '0;
      end else if (core_ce) begin
         r_out_beat <= '0;
         r_snap     <= OSW'(w_out_word);
      end else begin
         r_out_beat <= r_out_beat + 1'b1;
      end
   end

   always_comb begin
      w_out_chunk = '0;
      for (int unsigned k = 0; k < OUT_B; k++) begin
         if (r_out_beat == OBW'(k)) begin
            w_out_chunk = r_snap[k*P +: P];
         end
      end
   end

   assign io_out = {(r_out_beat == '0), w_out_chunk};

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic [PIN_W-1:0] r_sync [SYNC_STAGES];
   logic             w_m;
   logic [P-1:0]     w_c;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= io_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_m = r_sync[SYNC_STAGES-1][P];
   assign w_c = r_sync[SYNC_STAGES-1][P-1:0];

   // ------------------------------------------------------------------
   // Input deserialiser: beat sequencer
   // ------------------------------------------------------------------
   logic [IBW-1:0]  r_in_beat;
   logic [ISW-1:0]  r_in_buf;
   logic [IBW-1:0]  w_in_beat_nxt;
   logic [IBW-1:0]  w_slot;
   logic            w_store;
   logic            w_commit;
   logic            w_err;
   logic [ISW-1:0]  w_in_full;
   logic            w_unused_pad;

   logic [DATA_W-1:0] r_d_in;
   logic              r_intr;
   logic              r_ready;
   logic              r_fv;
   logic              r_fe;

   // A marker seen mid-frame restarts the frame at chunk 0 instead of
   // being stored as data; the partial chunks are simply overwritten later.
   always_comb begin
      w_in_beat_nxt = r_in_beat;
      w_slot        = '0;
      w_store       = 1'b0;
      w_commit      = 1'b0;
      w_err         = 1'b0;
      if (r_in_beat == '0) begin
         if (w_m) begin
            w_store = 1'b1;
            if (IN_B == 1) begin
               w_commit = 1'b1;
            end else begin
               w_in_beat_nxt = IBW'(1);
            end
         end
      end else if (w_m) begin
         w_err         = 1'b1;
         w_store       = 1'b1;
         w_in_beat_nxt = IBW'(1);
      end else begin
         w_store = 1'b1;
         w_slot  = r_in_beat;
         if (r_in_beat == IN_LAST) begin
            w_commit      = 1'b1;
            w_in_beat_nxt = '0;
         end else begin
            w_in_beat_nxt = r_in_beat + 1'b1;
         end
      end
   end

   // The final chunk is taken straight from the synchroniser so the commit
   // happens on the edge that stores it.
   always_comb begin
      w_in_full = '0;
      for (int unsigned k = 0; k < IN_B; k++) begin
         if (k == IN_B - 1) begin
            w_in_full[k*P +: P] = w_c;
         end else begin
            w_in_full[k*P +: P] = r_in_buf[k*P +: P];
         end
      end
   end

   // Padding bits of the input word and the unused top buffer chunk.
   assign w_unused_pad = ^{w_in_full, r_in_buf[ISW-1 -: P]};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_in_beat <= '0;
         r_in_buf  <= '0;
         r_d_in    <= '0;
         r_intr    <= 1'b0;
         r_ready   <= 1'b0;
         r_fv      <= 1'b0;
         r_fe      <= 1'b0;
      end else begin
         r_in_beat <= w_in_beat_nxt;
         r_fv      <= w_commit;
         r_fe      <= w_err;
         for (int unsigned k = 0; k < IN_B; k++) begin
            if (w_store && (w_slot == IBW'(k))) begin
               r_in_buf[k*P +: P] <= w_c;
            end
         end
         if (w_commit) begin
            r_d_in  <= w_in_full[DATA_W-1:0];
            r_intr  <= w_in_full[DATA_W];
            r_ready <= w_in_full[DATA_W+1];
         end
      end
   end

   assign core_d_in   = r_d_in;
   assign core_intr   = r_intr;
   assign core_ready  = r_ready;
   assign frame_valid = r_fv;
   assign frame_err   = r_fe;

endmodule

// File: tb/tb_pin_frame_mux.sv
// tb_pin_frame_mux
//   Drives two pin_frame_mux instances (default 12-pin and an 8-pin/8-bit
//   variant) from one stimulus schedule. Expected frames are computed from
//   whole words by chunk arithmetic and queued; monitors compare on
//   frame_valid / frame_err / frame end.
module tb_pin_frame_mux;

   localparam int SS = 2;

   localparam int A_PIN = 12, A_D = 16, A_S = 3;
   localparam int B_PIN = 8,  B_D = 8,  B_S = 3;
   localparam int A_P = A_PIN - 1, B_P = B_PIN - 1;
   localparam int A_OW = A_D + A_S + 1, B_OW = B_D + B_S + 1;
   localparam int A_IW = A_D + 2, B_IW = B_D + 2;
   localparam int unsigned A_OB = (A_OW + A_P - 1) / A_P;
   localparam int unsigned B_OB = (B_OW + B_P - 1) / B_P;
   // Both instances use two input beats, so one input schedule serves both.
   localparam int unsigned IB = (A_IW + A_P - 1) / A_P;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [A_PIN-1:0] a_io_in, a_io_out;
   logic [A_D-1:0]   a_dout, a_din;
   logic [A_S-1:0]   a_state;
   logic             a_sync, a_intr, a_ready, a_ce, a_fv, a_fe;

   logic [B_PIN-1:0] b_io_in, b_io_out;
   logic [B_D-1:0]   b_dout, b_din;
   logic [B_S-1:0]   b_state;
   logic             b_sync, b_intr, b_ready, b_ce, b_fv, b_fe;

   pin_frame_mux #(.PIN_W(A_PIN), .DATA_W(A_D), .STATE_W(A_S), .SYNC_STAGES(SS)) u_a (
      .clock(clk), .reset_n(rst_n), .io_in(a_io_in), .io_out(a_io_out),
      .core_d_out(a_dout), .core_state(a_state), .core_sync(a_sync),
      .core_d_in(a_din), .core_intr(a_intr), .core_ready(a_ready),
      .core_ce(a_ce), .frame_valid(a_fv), .frame_err(a_fe));

   pin_frame_mux #(.PIN_W(B_PIN), .DATA_W(B_D), .STATE_W(B_S), .SYNC_STAGES(SS)) u_b (
      .clock(clk), .reset_n(rst_n), .io_in(b_io_in), .io_out(b_io_out),
      .core_d_out(b_dout), .core_state(b_state), .core_sync(b_sync),
      .core_d_in(b_din), .core_intr(b_intr), .core_ready(b_ready),
      .core_ce(b_ce), .frame_valid(b_fv), .frame_err(b_fe));

   int tests = 0;
   int fails = 0;

   // tcyc: absolute cycle number. ocyc: cycles since reset release, which
   // gives the expected output beat position.
   int unsigned tcyc = 0;
   int unsigned ocyc = 0;
   always @(posedge clk) tcyc <= tcyc + 1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ocyc <= 0;
      else        ocyc <= ocyc + 1;
   end

   typedef struct {
      logic [63:0] w;
      int unsigned t;
   } exp_t;

   exp_t        a_in_q[$], b_in_q[$];
   int unsigned a_err_q[$], b_err_q[$];
   logic [63:0] a_out_q[$], b_out_q[$];
   logic [63:0] a_acc = '0, b_acc = '0;
   bit          out_rand = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, want, tcyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got event with value 0x%0h expected none (t=%0d)", name, act, tcyc);
   endtask

   function automatic logic [63:0] chunk(input logic [63:0] w, input int k, input int p);
      return (w >> (k * p)) & ((64'd1 << p) - 64'd1);
   endfunction

   // ---------------- input stimulus ----------------
   task automatic drive_beat(input logic [63:0] wa, input logic [63:0] wb, input int k);
      @(posedge clk); #1;
      a_io_in = A_PIN'(((k == 0) ? (64'd1 << A_P) : 64'd0) | chunk(wa, k, A_P));
      b_io_in = B_PIN'(((k == 0) ? (64'd1 << B_P) : 64'd0) | chunk(wb, k, B_P));
   endtask

   task automatic send_frame(input logic [63:0] wa, input logic [63:0] wb,
                             input int nb, output int unsigned t0);
      t0 = 0;
      for (int k = 0; k < nb; k++) begin
         drive_beat(wa, wb, k);
         if (k == 0) t0 = tcyc;
      end
      if (nb == int'(IB)) begin
         a_in_q.push_back('{w: wa, t: t0 + IB + SS});
         b_in_q.push_back('{w: wb, t: t0 + IB + SS});
      end
   endtask

   task automatic idle(input int n, input bit zero);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         a_io_in = zero ? '0 : {1'b0, A_P'($urandom)};
         b_io_in = zero ? '0 : {1'b0, B_P'($urandom)};
      end
   endtask

   function automatic logic [63:0] rand_w(input int bits);
      return {32'd0, $urandom} & ((64'd1 << bits) - 64'd1);
   endfunction

   task automatic clear_model();
      a_in_q.delete(); b_in_q.delete();
      a_err_q.delete(); b_err_q.delete();
      a_out_q.delete(); b_out_q.delete();
      a_out_q.push_back('0);
      b_out_q.push_back('0);
   endtask

   // Reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset(input int cycles);
      @(posedge clk); #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      check("rst_a_io_out", 64'(a_io_out), 64'h800);
      check("rst_b_io_out", 64'(b_io_out), 64'h80);
      check("rst_a_in", 64'({a_ready, a_intr, a_din}), 64'h0);
      check("rst_b_in", 64'({b_ready, b_intr, b_din}), 64'h0);
      check("rst_pulses", 64'({a_fv, a_fe, b_fv, b_fe}), 64'h0);
      check("rst_ce", 64'({a_ce, b_ce}), 64'h0);
      repeat (cycles) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // ---------------- core-side stimulus ----------------
   initial forever begin
      @(posedge clk); #1;
      if (out_rand) begin
         a_dout = A_D'($urandom); a_state = A_S'($urandom); a_sync = 1'($urandom);
         b_dout = B_D'($urandom); b_state = B_S'($urandom); b_sync = 1'($urandom);
      end
   end

   // Word present on the core during the last beat is what the next frame carries.
   initial forever begin
      @(negedge clk);
      if (rst_n && (ocyc % A_OB) == A_OB - 1) a_out_q.push_back(64'({a_sync, a_state, a_dout}));
      if (rst_n && (ocyc % B_OB) == B_OB - 1) b_out_q.push_back(64'({b_sync, b_state, b_dout}));
   end

   // ---------------- output monitor ----------------
   initial forever begin
      int unsigned pa, pb;
      @(negedge clk);
      if (rst_n) begin
         pa = ocyc % A_OB;
         pb = ocyc % B_OB;
         check("a_marker", 64'(a_io_out[A_P]), 64'(pa == 0));
         check("a_ce", 64'(a_ce), 64'(pa == A_OB - 1));
         check("b_marker", 64'(b_io_out[B_P]), 64'(pb == 0));
         check("b_ce", 64'(b_ce), 64'(pb == B_OB - 1));
         if (pa == 0) a_acc = '0;
         if (pb == 0) b_acc = '0;
         a_acc |= 64'(a_io_out[A_P-1:0]) << (pa * A_P);
         b_acc |= 64'(b_io_out[B_P-1:0]) << (pb * B_P);
         if (pa == A_OB - 1) begin
            if (a_out_q.size() == 0) unexpected("a_out_frame", a_acc);
            else check("a_out_frame", a_acc, a_out_q.pop_front());
         end
         if (pb == B_OB - 1) begin
            if (b_out_q.size() == 0) unexpected("b_out_frame", b_acc);
            else check("b_out_frame", b_acc, b_out_q.pop_front());
         end
      end
   end

   // ---------------- input monitor ----------------
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && a_fv) begin
         if (a_in_q.size() == 0) unexpected("a_commit", 64'(a_din));
         else begin
            e = a_in_q.pop_front();
            check("a_commit_word", 64'({a_ready, a_intr, a_din}), e.w);
            check("a_commit_time", 64'(tcyc), 64'(e.t));
         end
      end
      if (rst_n && b_fv) begin
         if (b_in_q.size() == 0) unexpected("b_commit", 64'(b_din));
         else begin
            e = b_in_q.pop_front();
            check("b_commit_word", 64'({b_ready, b_intr, b_din}), e.w);
            check("b_commit_time", 64'(tcyc), 64'(e.t));
         end
      end
      if (rst_n && a_fe) begin
         if (a_err_q.size() == 0) unexpected("a_frame_err", 64'(tcyc));
         else check("a_frame_err_time", 64'(tcyc), 64'(a_err_q.pop_front()));
      end
      if (rst_n && b_fe) begin
         if (b_err_q.size() == 0) unexpected("b_frame_err", 64'(tcyc));
         else check("b_frame_err_time", 64'(tcyc), 64'(b_err_q.pop_front()));
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int unsigned t1, t2;
      logic [63:0] wa, wb;
      int r;

      a_io_in = '0; b_io_in = '0;
      a_dout = 16'hA5C3; a_state = 3'b101; a_sync = 1'b1;
      b_dout = B_D'($urandom); b_state = B_S'($urandom); b_sync = 1'($urandom);

      // Power-on reset, asserted asynchronously.
      #1;
      rst_n = 1'b0;
      clear_model();
      #1;
      check("por_a_io_out", 64'(a_io_out), 64'h800);
      check("por_b_io_out", 64'(b_io_out), 64'h80);
      check("por_a_in", 64'({a_ready, a_intr, a_din, a_fv, a_fe}), 64'h0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Directed serialisation of {1, 101, A5C3}.
      repeat (4) @(posedge clk);
      @(negedge clk);
      if ((ocyc % A_OB) != 0) @(negedge clk);
      for (int f = 0; f < 2; f++) begin
         check("dir_out_beat0", 64'(a_io_out), 64'hDC3);
         check("dir_ce_beat0", 64'(a_ce), 64'h0);
         @(negedge clk);
         check("dir_out_beat1", 64'(a_io_out), 64'h1B4);
         check("dir_ce_beat1", 64'(a_ce), 64'h1);
         @(negedge clk);
      end

      // Directed input frame: 0xA34, 0x042, then 0x000.
      send_frame(64'h21234, rand_w(B_IW), IB, t1);
      idle(6, 1'b1);
      check("dir_in_d", 64'(a_din), 64'h1234);
      check("dir_in_ready_intr", 64'({a_ready, a_intr}), 64'h2);
      idle(5, 1'b1);
      check("dir_in_hold", 64'({a_ready, a_intr, a_din}), 64'h21234);

      // Asynchronous reset with non-zero state.
      do_reset(1);

      // Truncated frame: marker, marker again, then the final beat.
      wb = rand_w(B_IW);
      send_frame(64'h21234, rand_w(B_IW), 1, t1);
      send_frame(64'h21234, wb, IB, t2);
      a_err_q.push_back(t2 + SS + 1);
      b_err_q.push_back(t2 + SS + 1);
      idle(6, 1'b1);
      check("trunc_in_d", 64'({a_ready, a_intr, a_din}), 64'h21234);

      // Reset between beat 0 and beat 1 of an input frame.
      wa = rand_w(A_IW); wb = rand_w(B_IW);
      drive_beat(wa, wb, 0);
      drive_beat(wa, wb, 1);
      @(posedge clk);
      do_reset(1);
      repeat (8) @(posedge clk);
      #1;
      check("midrst_a_in", 64'({a_ready, a_intr, a_din}), 64'h0);
      check("midrst_b_in", 64'({b_ready, b_intr, b_din}), 64'h0);
      send_frame(rand_w(A_IW), rand_w(B_IW), IB, t1);
      idle(6, 1'b0);

      // Randomised traffic on both sides.
      out_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            send_frame(rand_w(A_IW), rand_w(B_IW), 1, t1);
            send_frame(rand_w(A_IW), rand_w(B_IW), IB, t2);
            a_err_q.push_back(t2 + SS + 1);
            b_err_q.push_back(t2 + SS + 1);
         end else if (r < 5) begin
            idle(int'($urandom_range(1, 3)), 1'b0);
            send_frame(rand_w(A_IW), rand_w(B_IW), IB, t1);
         end else begin
            send_frame(rand_w(A_IW), rand_w(B_IW), IB, t1);
         end
      end
      out_rand = 1'b0;
      idle(10, 1'b0);

      check("a_pending_commits", 64'(a_in_q.size()), 64'h0);
      check("b_pending_commits", 64'(b_in_q.size()), 64'h0);
      check("a_pending_errs", 64'(a_err_q.size()), 64'h0);
      check("b_pending_errs", 64'(b_err_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
